// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer between decode and a
// synchronous instruction memory with one cycle of read latency.
// Owns the fetch PC and issues one word address per cycle. A 2-entry
// skid buffer absorbs the read latency. Redirects, misaligned targets
// and the optional end-of-program halt are handled here.
// Build option: define IFETCH_EOF_HALT_EN to halt when the memory
// returns 32'hDEADBEEF. Without it, that word is an ordinary instruction.
//
// Handshake: the head entry moves to decode on a rising edge where
// out_valid and out_ready are both high. out_valid never depends on
// out_ready. The head stays stable while out_ready is low, unless a
// redirect flushes the buffer.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misaligned_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_ERR} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [1:0]  count;
  logic [31:0] buf0_instr, buf0_pc, buf1_instr, buf1_pc;
  logic        err_q;

  logic        pop, push_raw, eof, push, issue;
  logic [2:0]  occ;
  logic [1:0]  n_count;
  logic [31:0] n_b0_instr, n_b0_pc, n_b1_instr, n_b1_pc;

  assign mem_addr       = fetch_pc;
  assign out_valid      = (count != 2'd0);
  assign out_instr      = buf0_instr;
  assign out_pc         = buf0_pc;
  assign misaligned_err = err_q;
  assign dbg_state      = state;

`ifdef IFETCH_EOF_HALT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Handshake decisions and next buffer contents for the non-redirect case
  always_comb begin
    pop      = out_valid & out_ready;
    push_raw = (state == S_FETCH) & inflight & ~redirect_valid;
`ifdef IFETCH_EOF_HALT_EN
    eof      = push_raw & (mem_instr == 32'hDEADBEEF);
`else
    eof      = 1'b0;
`endif
    push     = push_raw & ~eof;
    occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue    = (state == S_FETCH) & ~redirect_valid & ~eof &
               (occ <= 3'(BUF_DEPTH - 1));

    n_count    = count;
    n_b0_instr = buf0_instr;
    n_b0_pc    = buf0_pc;
    n_b1_instr = buf1_instr;
    n_b1_pc    = buf1_pc;
    // Shift-style FIFO: entry 0 is always the head
    if (pop) begin
      n_b0_instr = buf1_instr;
      n_b0_pc    = buf1_pc;
      n_count    = count - 2'd1;
    end
    if (push) begin
      if (n_count == 2'd0) begin
        n_b0_instr = mem_instr;
        n_b0_pc    = inflight_pc;
      end else begin
        n_b1_instr = mem_instr;
        n_b1_pc    = inflight_pc;
      end
      n_count = n_count + 2'd1;
    end
  end

  // Control FSM, fetch PC, inflight tracking and skid buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      buf0_instr  <= 32'h0;
      buf0_pc     <= 32'h0;
      buf1_instr  <= 32'h0;
      buf1_pc     <= 32'h0;
      err_q       <= 1'b0;
`ifdef IFETCH_EOF_HALT_EN
      halted_q    <= 1'b0;
`endif
    end else if (redirect_valid && state != S_IDLE) begin
      // Redirect wins over everything: flush and drop the read in flight
      count    <= 2'd0;
      inflight <= 1'b0;
      fetch_pc <= redirect_pc;
`ifdef IFETCH_EOF_HALT_EN
      halted_q <= 1'b0;
`endif
      if (redirect_pc[1:0] == 2'b00) begin
        state <= S_FETCH;
        err_q <= 1'b0;
      end else begin
        state <= S_ERR;
        err_q <= 1'b1;
      end
    end else begin
      count      <= n_count;
      buf0_instr <= n_b0_instr;
      buf0_pc    <= n_b0_pc;
      buf1_instr <= n_b1_instr;
      buf1_pc    <= n_b1_pc;
      inflight   <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      case (state)
        S_IDLE: begin
          if (redirect_valid) fetch_pc <= redirect_pc;
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
`ifdef IFETCH_EOF_HALT_EN
          if (eof) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed sequence with an expected-PC queue.
// The queue holds the PCs decode should receive, in order. out_ready is
// high only while entries remain, so the bench sees exactly what it expects.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        misaligned_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr),
    .mem_instr(mem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted),
    .misaligned_err(misaligned_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // 64-word program; anything past the array reads as DEADBEEF
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] idx;
    idx = {2'b00, addr[31:2]};
    if (idx >= 32'd64) return 32'hDEADBEEF;
    if (idx == 32'd0) return 32'h0000_0013;
    return (idx << 20) | 32'h0000_0093;
  endfunction

  // synchronous instruction memory, one cycle of latency
  always @(posedge clk) mem_instr <= word_at(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // one clock: drive ready, score any transfer, then advance past the edge
  task automatic tick();
    logic [31:0] e;
    out_ready = (exp_q.size() != 0);
    if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      chk("deliver_pc", out_pc, e);
      chk("deliver_instr", out_instr, word_at(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_range(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_err", {31'b0, misaligned_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    tick();
    chk("idle_no_issue", mem_addr, 32'd0);

    // start and latency: E0 start, E1 issue, E2 push
    push_range(32'h0, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e0_valid", {31'b0, out_valid}, 32'd0);
    chk("e0_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    tick();
    chk("e1_valid", {31'b0, out_valid}, 32'd0);
    chk("e1_mem_addr", mem_addr, 32'd4);
    tick();
    chk("e2_valid", {31'b0, out_valid}, 32'd1);
    chk("e2_out_pc", out_pc, 32'd0);
    // one per cycle: exactly 8 ticks consume 8 entries
    repeat (8) tick();
    chk("throughput", 32'(exp_q.size()), 32'd0);

    // backpressure: ready low for 5 cycles
    repeat (5) tick();
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_head_pc", out_pc, 32'd32);
    chk("stall_mem_addr", mem_addr, 32'd40);
    push_range(32'd32, 16);
    drain(40);
    repeat (3) tick();
    chk("stall2_head_pc", out_pc, 32'd96);
    chk("stall2_mem_addr", mem_addr, 32'd104);

    // redirect with a full buffer
    redirect_to(32'h40);
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_mem_addr", mem_addr, 32'h40);
    push_range(32'h40, 8);
    tick();
    chk("redir_r1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("redir_r2_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_r2_pc", out_pc, 32'h40);
    drain(30);
    repeat (3) tick();

    // misaligned target
    redirect_to(32'h42);
    chk("mis_err", {31'b0, misaligned_err}, 32'd1);
    chk("mis_valid", {31'b0, out_valid}, 32'd0);
    chk("mis_state", {30'b0, dbg_state}, {30'b0, ST_ERR});
    repeat (3) tick();
    chk("mis_mem_addr", mem_addr, 32'h42);
    chk("mis_valid_hold", {31'b0, out_valid}, 32'd0);
    chk("mis_err_hold", {31'b0, misaligned_err}, 32'd1);
    redirect_to(32'h44);
    chk("mis_clear", {31'b0, misaligned_err}, 32'd0);
    chk("mis_clear_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    push_range(32'h44, 4);
    drain(20);

    // run past the end of the program
    redirect_to(32'hF0);
`ifdef IFETCH_EOF_HALT_EN
    push_range(32'hF0, 4);
    drain(20);
    repeat (3) tick();
    chk("eof_halted", {31'b0, halted}, 32'd1);
    chk("eof_state", {30'b0, dbg_state}, {30'b0, ST_HALT});
    chk("eof_valid", {31'b0, out_valid}, 32'd0);
`else
    push_range(32'hF0, 5);
    drain(20);
    repeat (3) tick();
    chk("eof_halted", {31'b0, halted}, 32'd0);
    chk("eof_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
`endif
    redirect_to(32'h0);
    chk("restart_halted", {31'b0, halted}, 32'd0);
    chk("restart_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
    push_range(32'h0, 3);
    drain(20);
    repeat (3) tick();

    // reset in the middle of a stream
    push_range(32'd12, 3);
    tick();
    tick();
    chk("pre_rst_left", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    push_range(32'h0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
